bsg_round_robin_n_to_1_ordered: RTL and testbench

- Downstream collector paired with the round-robin 1-to-n distributor. It pulls items from num_in_p parallel channels in strict round-robin order, so the original sequence is restored after the items pass through parallel lanes (FIFOs, processing units).
- Output is a 2-entry registered buffer with a valid/ready interface and channel tag.
- There is no combinational path from ready_and_i to yumi_o.

---
 rtl/bsg_round_robin_n_to_1_ordered.sv | 143 ++++++++++++++
 tb/tb_bsg_round_robin_n_to_1_ordered.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_round_robin_n_to_1_ordered.sv
// Ordered n-to-1 collector: dequeues input channels strictly in round-robin turn
// (burst_len_p items per turn) into a 2-entry registered output buffer with a channel tag.
module bsg_round_robin_n_to_1_ordered #(
  // Defaults exist only so the module elaborates standalone; instantiators set all three.
  parameter int width_p     = 8,
  parameter int num_in_p    = 2,
  parameter int burst_len_p = 1
) (
  input  logic                                          clk_i,
  input  logic                                          reset_i,
  input  logic [num_in_p*width_p-1:0]                   data_i,
  input  logic [num_in_p-1:0]                           v_i,
  output logic [num_in_p-1:0]                           yumi_o,
  output logic [width_p-1:0]                            data_o,
  output logic [((num_in_p > 1) ? $clog2(num_in_p) : 1)-1:0] tag_o,
  output logic                                          v_o,
  input  logic                                          ready_and_i
);

  localparam int ptr_w_lp  = (num_in_p > 1) ? $clog2(num_in_p) : 1;
  localparam int beat_w_lp = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;

  logic [ptr_w_lp-1:0] r_ptr;
  logic [1:0]          r_count;
  logic                r_head;
  logic                r_tail;
  logic [width_p-1:0]  r_data [2];
  logic [ptr_w_lp-1:0] r_tag  [2];

  logic                w_space;
  logic                w_cur_v;
  logic [width_p-1:0]  w_cur_data;
  logic                w_enq;
  logic                w_deq;
  logic                w_last_beat;

  // Select the current channel by compare rather than indexing, so a
  // non-power-of-2 channel count never reads past the last channel.
  always_comb begin
    w_cur_v    = 1'b0;
    w_cur_data = '0;
    for (int k = 0; k < num_in_p; k++) begin
      if (r_ptr == ptr_w_lp'(k)) begin
        w_cur_v    = v_i[k];
        w_cur_data = data_i[k*width_p +: width_p];
      end
    end
  end

  // Space comes only from registered count: ready_and_i never reaches yumi_o.
  assign w_space = (r_count != 2'd2);
  assign w_enq   = ~reset_i & w_space & w_cur_v;
  assign w_deq   = (r_count != 2'd0) & ready_and_i;

  always_comb begin
    yumi_o = '0;
    for (int k = 0; k < num_in_p; k++) begin
      yumi_o[k] = w_enq & (r_ptr == ptr_w_lp'(k));
    end
  end

  if (burst_len_p == 1) begin : g_no_beat
    assign w_last_beat = 1'b1;
  end else begin : g_beat
    logic [beat_w_lp-1:0] r_beat;

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_beat <= '0;
      end else if (w_enq) begin
        if (w_last_beat) r_beat <= '0;
        else             r_beat <= r_beat + 1'b1;
      end
    end

    assign w_last_beat = (r_beat == beat_w_lp'(burst_len_p - 1));
  end

  if (num_in_p == 1) begin : g_single
    assign r_ptr = '0;
  end else begin : g_multi
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_ptr <= '0;
      end else if (w_enq && w_last_beat) begin
        r_ptr <= (r_ptr == ptr_w_lp'(num_in_p - 1)) ? '0 : r_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      if (w_enq) r_tail <= ~r_tail;
      if (w_deq) r_head <= ~r_head;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_data[r_tail] <= w_cur_data;
      r_tag[r_tail]  <= r_ptr;
    end
  end

  assign v_o    = ~reset_i & (r_count != 2'd0);
  assign data_o = r_data[r_head];
  assign tag_o  = r_tag[r_head];

`ifndef SYNTHESIS
  int r_stuck [num_in_p];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert ($onehot0(yumi_o)) else $error("yumi_o has more than one bit set");
      assert (r_count <= 2'd2) else $error("buffer count exceeds 2");
    end
  end

  // A channel left valid out of turn for long usually means the distributor and
  // collector disagree on order.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < num_in_p; k++) begin
      if (reset_i || !v_i[k] || (r_ptr == ptr_w_lp'(k))) begin
        r_stuck[k] <= 0;
      end else begin
        r_stuck[k] <= r_stuck[k] + 1;
        if (r_stuck[k] == 1000) $warning("channel %0d valid out of turn for 1000 cycles", k);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bsg_round_robin_n_to_1_ordered.sv
// Directed bench for the ordered round-robin collector: three instances cover
// 3 channels/burst 1, 2 channels/burst 3 and 5 channels/burst 1.
module tb_bsg_round_robin_n_to_1_ordered;

  logic clk;
  logic rst;

  // instance A: 3 channels, burst 1
  logic [23:0] a_data;
  logic [2:0]  a_v;
  logic [2:0]  a_yumi;
  logic [7:0]  a_dout;
  logic [1:0]  a_tag;
  logic        a_vo;
  logic        a_ready;

  // instance B: 2 channels, burst 3
  logic [15:0] b_data;
  logic [1:0]  b_v;
  logic [1:0]  b_yumi;
  logic [7:0]  b_dout;
  logic [0:0]  b_tag;
  logic        b_vo;
  logic        b_ready;

  // instance C: 5 channels, burst 1
  logic [39:0] c_data;
  logic [4:0]  c_v;
  logic [4:0]  c_yumi;
  logic [7:0]  c_dout;
  logic [2:0]  c_tag;
  logic        c_vo;
  logic        c_ready;

  int n_cmp;
  int n_err;

  int a_src [3];
  int b_src [2];
  int c_src [5];
  int a_outs;
  int a_taken;
  logic [9:0] exp_q [$];

  bsg_round_robin_n_to_1_ordered #(.width_p(8), .num_in_p(3), .burst_len_p(1)) u_a (
    .clk_i(clk), .reset_i(rst), .data_i(a_data), .v_i(a_v), .yumi_o(a_yumi),
    .data_o(a_dout), .tag_o(a_tag), .v_o(a_vo), .ready_and_i(a_ready)
  );

  bsg_round_robin_n_to_1_ordered #(.width_p(8), .num_in_p(2), .burst_len_p(3)) u_b (
    .clk_i(clk), .reset_i(rst), .data_i(b_data), .v_i(b_v), .yumi_o(b_yumi),
    .data_o(b_dout), .tag_o(b_tag), .v_o(b_vo), .ready_and_i(b_ready)
  );

  bsg_round_robin_n_to_1_ordered #(.width_p(8), .num_in_p(5), .burst_len_p(1)) u_c (
    .clk_i(clk), .reset_i(rst), .data_i(c_data), .v_i(c_v), .yumi_o(c_yumi),
    .data_o(c_dout), .tag_o(c_tag), .v_o(c_vo), .ready_and_i(c_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic a_drive();
    for (int k = 0; k < 3; k++) a_data[k*8 +: 8] = 8'(k*16 + a_src[k]);
  endtask

  task automatic b_drive();
    for (int k = 0; k < 2; k++) b_data[k*8 +: 8] = 8'(k*16 + b_src[k]);
  endtask

  task automatic c_drive();
    for (int k = 0; k < 5; k++) c_data[k*8 +: 8] = 8'(k*16 + c_src[k]);
  endtask

  // Sources restart at item 0; the expected order is channel-major per round.
  task automatic a_restart();
    a_src   = '{0, 0, 0};
    a_outs  = 0;
    a_taken = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 3; k++)
        exp_q.push_back({2'(k), 8'(k*16 + i)});
    a_drive();
  endtask

  // One clock of instance A: sample at negedge, score outputs, advance sources.
  task automatic a_cycle(output logic [2:0] y, output logic vo, output logic [9:0] head);
    logic [9:0] exp;
    @(negedge clk);
    y    = a_yumi;
    vo   = a_vo;
    head = {a_tag, a_dout};
    check_eq("a_yumi_onehot", 32'($onehot0(a_yumi)), 32'd1);
    if (a_vo && a_ready) begin
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check_eq("a_out", 32'(head), 32'(exp));
      end else begin
        check_eq("a_out_extra", 32'(exp_q.size()), 32'd1);
      end
      a_outs++;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) if (y[k]) a_src[k]++;
    a_taken += $countones(y);
    a_drive();
  endtask

  logic [1:0]  exp_yumi_b [8] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1};
  logic [8:0]  exp_out_b  [7] = '{9'h000, 9'h001, 9'h002, 9'h110, 9'h111, 9'h112, 9'h003};
  logic [10:0] exp_out_c  [12] = '{11'h000, 11'h110, 11'h220, 11'h330, 11'h440, 11'h001,
                                   11'h111, 11'h221, 11'h331, 11'h441, 11'h002, 11'h112};

  initial begin
    logic [2:0] y;
    logic       vo;
    logic [9:0] head;
    logic [1:0] yb;
    logic [4:0] yc;
    int         acc;

    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    a_v = 3'b111; a_ready = 1'b1;
    b_v = 2'b00;  b_ready = 1'b1; b_data = '0;
    c_v = 5'b0;   c_ready = 1'b1; c_data = '0;
    b_src = '{0, 0};
    c_src = '{0, 0, 0, 0, 0};
    a_restart();

    // reset: no valid out, no dequeue even with inputs valid
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rst_a_vo", 32'(a_vo), 32'd0);
      check_eq("rst_a_yumi", 32'(a_yumi), 32'd0);
      check_eq("rst_b_vo", 32'(b_vo), 32'd0);
      check_eq("rst_c_vo", 32'(c_vo), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic order: first output one cycle after first dequeue, then 1 per cycle
    a_cycle(y, vo, head);
    check_eq("t1_first_yumi", 32'(y), 32'd1);
    check_eq("t1_first_vo", 32'(vo), 32'd0);
    for (int i = 0; i < 11; i++) begin
      a_cycle(y, vo, head);
      check_eq("t1_thru_vo", 32'(vo), 32'd1);
    end

    // stall on channel 1 while 0 and 2 stay valid
    a_v = 3'b101;
    a_cycle(y, vo, head);
    check_eq("t2_ch0_yumi", 32'(y), 32'd1);
    for (int s = 0; s < 5; s++) begin
      a_cycle(y, vo, head);
      check_eq("t2_stall_yumi", 32'(y), 32'd0);
      if (s >= 1) check_eq("t2_gap_vo", 32'(vo), 32'd0);
    end
    a_v = 3'b111;
    a_cycle(y, vo, head);
    check_eq("t2_resume_yumi", 32'(y), 32'd2);
    for (int i = 0; i < 5; i++) a_cycle(y, vo, head);

    // backpressure from empty: two accepted, head holds
    a_v = 3'b000;
    for (int i = 0; i < 2; i++) a_cycle(y, vo, head);
    a_v = 3'b111;
    a_ready = 1'b0;
    acc = 0;
    for (int b = 0; b < 4; b++) begin
      a_cycle(y, vo, head);
      if (y != 3'b000) acc++;
      if (b >= 1) begin
        check_eq("t3_hold_vo", 32'(vo), 32'd1);
        check_eq("t3_hold_head", 32'(head), 32'(exp_q[0]));
      end
      if (b >= 2) check_eq("t3_full_yumi", 32'(y), 32'd0);
    end
    check_eq("t3_accepted", 32'(acc), 32'd2);
    a_ready = 1'b1;
    for (int i = 0; i < 10; i++) a_cycle(y, vo, head);
    a_v = 3'b000;
    for (int i = 0; i < 3; i++) a_cycle(y, vo, head);
    check_eq("t3_no_loss", 32'(a_outs), 32'(a_taken));

    // reset mid-stream with count=2, ptr=2
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_restart();
    a_v = 3'b111;
    a_ready = 1'b0;
    a_cycle(y, vo, head);
    check_eq("t6_fill0", 32'(y), 32'd1);
    a_cycle(y, vo, head);
    check_eq("t6_fill1", 32'(y), 32'd2);
    a_cycle(y, vo, head);
    check_eq("t6_full", 32'(y), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_yumi", 32'(a_yumi), 32'd0);
    check_eq("t6_rst_vo", 32'(a_vo), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_restart();
    a_ready = 1'b1;
    a_cycle(y, vo, head);
    check_eq("t6_post_vo", 32'(vo), 32'd0);
    check_eq("t6_post_yumi", 32'(y), 32'd1);
    a_cycle(y, vo, head);
    check_eq("t6_post_yumi2", 32'(y), 32'd2);
    check_eq("t6_post_head", 32'(head), 32'h000);
    for (int i = 0; i < 4; i++) a_cycle(y, vo, head);
    a_v = 3'b000;

    // burst mode: 2 channels, 3 per turn
    b_v = 2'b11;
    b_drive();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      yb = b_yumi;
      check_eq("t4_yumi", 32'(yb), 32'(exp_yumi_b[c]));
      if (c >= 1) begin
        check_eq("t4_vo", 32'(b_vo), 32'd1);
        check_eq("t4_out", 32'({b_tag, b_dout}), 32'(exp_out_b[c-1]));
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) if (yb[k]) b_src[k]++;
      b_drive();
    end
    b_v = 2'b00;

    // non-power-of-2 wrap: 5 channels
    c_v = 5'b11111;
    c_drive();
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      yc = c_yumi;
      check_eq("t5_yumi", 32'(yc), 32'(5'd1 << (c % 5)));
      if (c_vo) check_eq("t5_tag_range", 32'(c_tag < 3'd5), 32'd1);
      if (c >= 1) begin
        check_eq("t5_vo", 32'(c_vo), 32'd1);
        check_eq("t5_out", 32'({c_tag, c_dout}), 32'(exp_out_c[c-1]));
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) if (yc[k]) c_src[k]++;
      c_drive();
    end
    c_v = 5'b0;

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
